// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes the raw bus, frames 11-bit packets and
// decodes E0/F0 prefixes into one strobed make code per key press.
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_info,
  output logic       ps2_enable,
  output logic       ps2_extended,
  output logic       frame_error
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TMO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [7:0]    info_d;
  logic          ext_out_d, enable_d, ferr_d;
  logic          frame_ok;

  // Synchronizers reset to 1 so an idle bus never looks like a falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall     = clk_prev & ~clk_s2;
  assign frame_ok = data_s2 & (^{shift_q, parity_q});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      ps2_info     <= 8'h00;
      ps2_extended <= 1'b0;
      ps2_enable   <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      ps2_info     <= info_d;
      ps2_extended <= ext_out_d;
      ps2_enable   <= enable_d;
      frame_error  <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    info_d    = ps2_info;
    ext_out_d = ps2_extended;
    enable_d  = 1'b0;
    ferr_d    = 1'b0;

    if (state_q == IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q < TMO_MAX) begin
      tmo_d = tmo_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (fall && !data_s2) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_s2, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_s2;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!frame_ok) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (brk_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else begin
            info_d    = shift_q;
            ext_out_d = ext_q;
            enable_d  = 1'b1;
            ext_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Stalled keyboard clock: the last idle cycle before the count reaches
    // TIMEOUT_CYCLES abandons the frame so the error lands exactly on time.
    if (state_q != IDLE && !fall && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      tmo_d   = '0;
      shift_d = '0;
      ferr_d  = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames bit by bit and checks
// strobes, decoded codes, prefix handling, errors, timeout and reset recovery.
module tb_ps2_scancode_rx;

  localparam int TMO = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_info;
  logic       ps2_enable, ps2_extended, frame_error;

  int n_checks = 0;
  int n_fail   = 0;
  int half     = 10;

  int         en_cnt = 0, fe_cnt = 0, overlap_cnt = 0;
  logic [7:0] last_info = 8'h00;
  logic       last_ext = 1'b0;

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_info    (ps2_info),
    .ps2_enable  (ps2_enable),
    .ps2_extended(ps2_extended),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ps2_enable) begin
      en_cnt++;
      last_info = ps2_info;
      last_ext  = ps2_extended;
    end
    if (frame_error) fe_cnt++;
    if (ps2_enable && frame_error) overlap_cnt++;
  end

  task automatic send_bit(input logic b);
    repeat (half) @(negedge clock);
    ps2_data = b;
    repeat (half) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (half) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(stop_bit);
    repeat (6) @(negedge clock);
    ps2_data = 1'b1;
  endtask

  task automatic expect_counts(input string name, input int en0, input int fe0,
                               input int den, input int dfe);
    n_checks++;
    if (en_cnt - en0 !== den) begin
      n_fail++;
      $display("FAIL %s strobes: got %0d expected %0d", name, en_cnt - en0, den);
    end
    n_checks++;
    if (fe_cnt - fe0 !== dfe) begin
      n_fail++;
      $display("FAIL %s frame_errors: got %0d expected %0d", name, fe_cnt - fe0, dfe);
    end
  endtask

  task automatic expect_code(input string name, input logic [7:0] info, input logic ext);
    n_checks++;
    if (last_info !== info) begin
      n_fail++;
      $display("FAIL %s ps2_info: got %h expected %h", name, last_info, info);
    end
    n_checks++;
    if (last_ext !== ext) begin
      n_fail++;
      $display("FAIL %s ps2_extended: got %b expected %b", name, last_ext, ext);
    end
  endtask

  task automatic expect_reset_outputs(input string name);
    n_checks++;
    if ({ps2_info, ps2_enable, ps2_extended, frame_error} !== 11'h000) begin
      n_fail++;
      $display("FAIL %s outputs: got info=%h en=%b ext=%b fe=%b expected all zero",
               name, ps2_info, ps2_enable, ps2_extended, frame_error);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    expect_reset_outputs("reset_hold");
    reset = 1'b1;
    repeat (5) @(negedge clock);
    expect_reset_outputs("reset_release");
    expect_counts("reset_quiet", 0, 0, 0, 0);
  endtask

  task automatic test_make_code;
    int en0 = en_cnt, fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_counts("make_1c", en0, fe0, 1, 0);
    expect_code("make_1c", 8'h1C, 1'b0);
  endtask

  task automatic test_extended;
    int en0 = en_cnt, fe0 = fe_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_counts("ext_prefix", en0, fe0, 0, 0);
    send_frame(8'h75, 1'b0, 1'b1);
    expect_counts("ext_75", en0, fe0, 1, 0);
    expect_code("ext_75", 8'h75, 1'b1);
  endtask

  task automatic test_break;
    int en0 = en_cnt, fe0 = fe_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_counts("break_release", en0, fe0, 0, 0);
    send_frame(8'h32, 1'b0, 1'b1);
    expect_counts("break_next", en0, fe0, 1, 0);
    expect_code("break_next", 8'h32, 1'b0);
  endtask

  task automatic test_errors;
    int en0 = en_cnt, fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    expect_counts("bad_parity", en0, fe0, 0, 1);
    n_checks++;
    if (ps2_info !== 8'h32) begin
      n_fail++;
      $display("FAIL bad_parity ps2_info held: got %h expected 32", ps2_info);
    end
    en0 = en_cnt; fe0 = fe_cnt;
    send_frame(8'h2A, 1'b0, 1'b0);
    expect_counts("bad_stop", en0, fe0, 0, 1);
  endtask

  task automatic test_timeout;
    int en0 = en_cnt, fe0 = fe_cnt;
    int got = -1;
    int expect_k = TMO + 3 - half;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    for (int k = 1; k <= 300; k++) begin
      @(posedge clock);
      #1;
      if (frame_error) begin
        got = k;
        break;
      end
    end
    n_checks++;
    if (got !== expect_k) begin
      n_fail++;
      $display("FAIL timeout latency: got %0d cycles expected %0d", got, expect_k);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (frame_error !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout pulse width: got frame_error=%b expected 0", frame_error);
    end
    repeat (4) @(negedge clock);
    expect_counts("timeout", en0, fe0, 0, 1);
    en0 = en_cnt; fe0 = fe_cnt;
    send_frame(8'h21, 1'b0, 1'b1);
    expect_counts("after_timeout", en0, fe0, 1, 0);
    expect_code("after_timeout", 8'h21, 1'b0);
  endtask

  task automatic test_mid_reset;
    int en0 = en_cnt, fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    expect_reset_outputs("mid_reset_low");
    reset = 1'b1;
    repeat (TMO + 20) @(negedge clock);
    expect_reset_outputs("mid_reset_after");
    expect_counts("mid_reset", en0, fe0, 0, 0);
    send_frame(8'h22, 1'b0, 1'b1);
    expect_counts("after_reset", en0, fe0, 1, 0);
    expect_code("after_reset", 8'h22, 1'b0);
  endtask

  task automatic test_back_to_back;
    int en0 = en_cnt, fe0 = fe_cnt;
    half = 1;
    send_frame(8'h15, 1'b0, 1'b1);
    expect_code("b2b_15", 8'h15, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b0, 1'b1);
    expect_counts("b2b", en0, fe0, 2, 0);
    expect_code("b2b_6b", 8'h6B, 1'b1);
    half = 10;
    n_checks++;
    if (overlap_cnt !== 0) begin
      n_fail++;
      $display("FAIL exclusive strobes: got %0d overlapping cycles expected 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_make_code();
    test_extended();
    test_break();
    test_errors();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: system clocks allowed between PS/2 clock falling edges inside a frame before the frame is abandoned.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous to clock.
REQ-005 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous to clock.
REQ-006 SHALL have port ps2_info  output  8  last accepted make code; feeds characterData ps2_info.
REQ-007 SHALL have port ps2_enable  output  1  one-cycle strobe marking ps2_info as new; feeds characterData ps2_enable.
REQ-008 SHALL have port ps2_extended  output  1  high with ps2_enable when the code was E0-prefixed.
REQ-009 SHALL have port frame_error  output  1  one-cycle strobe on a parity, stop-bit or timeout failure.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer.
REQ-011 SHALL register the synchronized clock once more and detect a falling edge as previous=1 and current=0.
REQ-012 SHALL sample synchronized ps2_data only in falling-edge cycles.
REQ-013 SHALL use states IDLE, DATA, PARITY and STOP.
REQ-014 SHALL, in IDLE on an edge with data=0 (start bit), go to DATA with the bit counter at 0.
REQ-015 SHALL, in IDLE on an edge with data=1, stay in IDLE and raise no error.
REQ-016 SHALL, in DATA, shift one bit per edge LSB first into an 8-bit register, moving to PARITY after the 8th bit (counter 0..7).
REQ-017 SHALL, in PARITY, store the sampled bit and go to STOP on the next edge.
REQ-018 SHALL, in STOP, return to IDLE on the edge; the frame is valid only if stop bit=1 and the 8 data bits plus parity bit have odd parity.
REQ-019 SHALL, on an invalid frame, pulse frame_error for 1 cycle (the cycle after the STOP edge), discard the byte and clear both prefix flags.
REQ-020 SHALL count clocks since the last edge while not in IDLE; when the count reaches TIMEOUT_CYCLES it returns to IDLE, pulses frame_error once, discards the partial byte and clears the prefix flags.
REQ-021 SHALL size the timeout counter to clog2(TIMEOUT_CYCLES+1) bits, saturating with no wrap.
REQ-022 SHALL, on a valid byte 8'hE0, set ext_flag with no strobe.
REQ-023 SHALL, on a valid byte 8'hF0, set brk_flag with no strobe.
REQ-024 SHALL, on any other valid byte with brk_flag=0, set ps2_info=byte, ps2_extended=ext_flag and ps2_enable=1 in the cycle after the STOP edge, then clear ext_flag.
REQ-025 SHALL, on any other valid byte with brk_flag=1, suppress the strobe and clear both flags (key release).
REQ-026 SHALL hold ps2_enable for exactly 1 cycle per accepted code.
REQ-027 SHALL hold ps2_info and ps2_extended until the next accepted code.
REQ-028 SHALL handle a new start edge in the same cycle as the ps2_enable strobe normally, without losing the strobe.
REQ-029 SHALL fix latency at 1 clock from the STOP-edge cycle to ps2_enable or frame_error.
REQ-030 SHALL allow at most one of ps2_enable and frame_error high in any cycle.

Reset
REQ-031 SHALL, while reset is low, force state=IDLE, ps2_info=8'h00, ps2_enable=0, ps2_extended=0, frame_error=0, all flags, counters and shift register to 0, and synchronizer flops to 1 (idle bus).
REQ-032 SHALL, if reset is asserted mid-frame, drop the partial frame with no strobe; after release, reception restarts at the next start bit.

Verification
REQ-033 SHALL be verified with: frame 0x1C, parity 0, stop 1 -> one ps2_enable pulse, ps2_info=1C, ps2_extended=0.
REQ-034 SHALL be verified with: frames E0 then 75 -> single strobe, ps2_info=75, ps2_extended=1; no strobe for E0.
REQ-035 SHALL be verified with: frames F0 then 1C, then 32 -> no strobe for F0/1C; strobe with ps2_info=32.
REQ-036 SHALL be verified with: frame 0x1C with parity bit 1 -> frame_error pulse, no ps2_enable, ps2_info unchanged.
REQ-037 SHALL be verified with: TIMEOUT_CYCLES=100, ps2_clk stopped after 4 data bits -> frame_error 100 cycles after the last edge; the next full frame 0x21 is received correctly.
REQ-038 SHALL be verified with: reset low for 3 cycles in the middle of the DATA state -> outputs at reset values, no strobe; the following frame 0x22 gives ps2_info=22.
